ctl_pipe: RTL and testbench

- Carries the per-instruction control bundles produced in ID (`ID_ctlex`, `ID_ctlm`, `ID_ctlwb`) through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Unpacks each bundle into the individual enables used by the EX, MEM and WB datapaths.
- Inserts bubbles on load-use stalls, resolves branches in MEM (`MEM_pcsrc`) and squashes wrong-path instructions.
- Counts retired instructions.

---
 rtl/ctl_pipe.sv | 137 +++++++++++++
 tb/tb_ctl_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ctl_pipe.sv
// Carries ID control bundles through the EX, MEM and WB stage registers and counts retired instructions.
// Fixed 1-cycle-per-stage latency. A load-use stall or a taken branch inserts bubbles, and stages never freeze.
module ctl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ID_ctlex,
  input  logic [2:0]       ID_ctlm,
  input  logic [1:0]       ID_ctlwb,
  input  logic             ID_valid,
  input  logic             stall,
  input  logic             EX_zero,
  output logic             EX_regdst,
  output logic [1:0]       EX_aluop,
  output logic             EX_alusrc,
  output logic             MEM_branch,
  output logic             MEM_memread,
  output logic             MEM_memwrite,
  output logic             MEM_pcsrc,
  output logic             WB_regwrite,
  output logic             WB_memtoreg,
  output logic             EX_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic [CNT_W-1:0] retired
);

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ctlex_t;

  typedef struct packed {
    logic branch;
    logic memread;
    logic memwrite;
  } ctlm_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } ctlwb_t;

  typedef struct packed {
    ctlex_t ex;
    ctlm_t  m;
    ctlwb_t wb;
    logic   valid;
  } ex_stage_t;

  typedef struct packed {
    ctlm_t  m;
    ctlwb_t wb;
    logic   zero;
    logic   valid;
  } mem_stage_t;

  typedef struct packed {
    ctlwb_t wb;
    logic   valid;
  } wb_stage_t;

  ex_stage_t        ex_q, ex_d;
  mem_stage_t       mem_q, mem_d;
  wb_stage_t        wb_q, wb_d;
  logic [CNT_W-1:0] retired_q;
  logic             pcsrc;

  assign pcsrc = mem_q.m.branch & mem_q.zero & mem_q.valid;

  // A bubble is the all-zero bundle, so a flush, a stall and an empty ID slot all load '0.
  always_comb begin
    ex_d = '0;
    if (!pcsrc && !stall && ID_valid) begin
      ex_d.ex    = ID_ctlex;
      ex_d.m     = ID_ctlm;
      ex_d.wb    = ID_ctlwb;
      ex_d.valid = 1'b1;
    end
  end

  // A taken branch in MEM squashes the wrong-path instruction leaving EX.
  always_comb begin
    mem_d = '0;
    if (!pcsrc) begin
      mem_d.m     = ex_q.m;
      mem_d.wb    = ex_q.wb;
      mem_d.zero  = EX_zero;
      mem_d.valid = ex_q.valid;
    end
  end

  always_comb begin
    wb_d       = '0;
    wb_d.wb    = mem_q.wb;
    wb_d.valid = mem_q.valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      if (wb_q.valid) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign EX_regdst    = ex_q.ex.regdst;
  assign EX_aluop     = ex_q.ex.aluop;
  assign EX_alusrc    = ex_q.ex.alusrc;
  assign EX_valid     = ex_q.valid;
  assign MEM_branch   = mem_q.m.branch;
  assign MEM_memread  = mem_q.m.memread;
  assign MEM_memwrite = mem_q.m.memwrite;
  assign MEM_pcsrc    = pcsrc;
  assign MEM_valid    = mem_q.valid;
  assign WB_regwrite  = wb_q.wb.regwrite;
  assign WB_memtoreg  = wb_q.wb.memtoreg;
  assign WB_valid     = wb_q.valid;
  assign retired      = retired_q;

  // Enables are never gated by valid, so an empty stage must carry a zero bundle.
  a_bubble_zero: assert property (@(posedge clk) disable iff (rst)
    (!ex_q.valid |-> (ex_q.ex == '0 && ex_q.m == '0 && ex_q.wb == '0)) and
    (!mem_q.valid |-> (mem_q.m == '0 && mem_q.wb == '0)) and
    (!wb_q.valid |-> (wb_q.wb == '0)));

endmodule

// File: tb/tb_ctl_pipe.sv
// Directed bench for ctl_pipe: the stimulus queues hand-computed post-edge outputs, and a monitor compares them.
module tb_ctl_pipe;
  localparam int CW = 4;

  localparam logic [3:0] R_EX  = 4'b1100;
  localparam logic [2:0] R_M   = 3'b000;
  localparam logic [1:0] R_WB  = 2'b10;
  localparam logic [3:0] LW_EX = 4'b0001;
  localparam logic [2:0] LW_M  = 3'b010;
  localparam logic [1:0] LW_WB = 2'b11;
  localparam logic [3:0] BQ_EX = 4'b0010;
  localparam logic [2:0] BQ_M  = 3'b100;
  localparam logic [1:0] BQ_WB = 2'b00;
  localparam logic [3:0] SW_EX = 4'b0001;
  localparam logic [2:0] SW_M  = 3'b001;
  localparam logic [1:0] SW_WB = 2'b00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    ID_ctlex = '0;
  logic [2:0]    ID_ctlm = '0;
  logic [1:0]    ID_ctlwb = '0;
  logic          ID_valid = 1'b0;
  logic          stall = 1'b0;
  logic          EX_zero = 1'b0;
  logic          EX_regdst, EX_alusrc;
  logic [1:0]    EX_aluop;
  logic          MEM_branch, MEM_memread, MEM_memwrite, MEM_pcsrc;
  logic          WB_regwrite, WB_memtoreg;
  logic          EX_valid, MEM_valid, WB_valid;
  logic [CW-1:0] retired;

  ctl_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_ctlex(ID_ctlex), .ID_ctlm(ID_ctlm), .ID_ctlwb(ID_ctlwb),
    .ID_valid(ID_valid), .stall(stall), .EX_zero(EX_zero),
    .EX_regdst(EX_regdst), .EX_aluop(EX_aluop), .EX_alusrc(EX_alusrc),
    .MEM_branch(MEM_branch), .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
    .MEM_pcsrc(MEM_pcsrc), .WB_regwrite(WB_regwrite), .WB_memtoreg(WB_memtoreg),
    .EX_valid(EX_valid), .MEM_valid(MEM_valid), .WB_valid(WB_valid),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic [16:0] act;

  // Layout: {ex[3:0], ex_v, m[2:0], pcsrc, mem_v, wb[1:0], wb_v, retired[3:0]}
  assign act = {EX_regdst, EX_aluop, EX_alusrc, EX_valid,
                MEM_branch, MEM_memread, MEM_memwrite, MEM_pcsrc, MEM_valid,
                WB_regwrite, WB_memtoreg, WB_valid, retired};

  function automatic logic [16:0] e(input logic [3:0] x, input logic xv, input logic [2:0] m,
                                    input logic pc, input logic mv, input logic [1:0] w,
                                    input logic wv, input logic [3:0] r);
    return {x, xv, m, pc, mv, w, wv, r};
  endfunction

  // Inputs are driven for the next rising edge; ev is the output state right after that edge.
  task automatic step(input logic r, input logic iv, input logic st, input logic z,
                      input logic [3:0] x, input logic [2:0] m, input logic [1:0] w,
                      input logic [16:0] ev, input string nm);
    exp_t t;
    @(negedge clk);
    rst = r; ID_valid = iv; stall = st; EX_zero = z;
    ID_ctlex = x; ID_ctlm = m; ID_ctlwb = w;
    t.v = ev;
    t.nm = nm;
    q.push_back(t);
  endtask

  task automatic idle(input logic [16:0] ev, input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 3'b0, 2'b0, ev, nm);
  endtask

  initial begin : monitor
    exp_t t;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        t = q.pop_front();
        n_tests++;
        if (act !== t.v) begin
          n_fail++;
          $display("FAIL %s: got %b, expected %b", t.nm, act, t.v);
        end
      end
    end
  end

  initial begin : stim
    logic       mv, wv;
    logic [1:0] w;
    logic [3:0] r;

    step(1, 1, 0, 0, R_EX, R_M, R_WB, e(0, 0, 0, 0, 0, 0, 0, 0), "reset_c0");
    step(1, 1, 0, 0, R_EX, R_M, R_WB, e(0, 0, 0, 0, 0, 0, 0, 0), "reset_c1");

    step(0, 1, 0, 0, R_EX, R_M, R_WB, e(R_EX, 1, 0, 0, 0, 0, 0, 0), "r_ex");
    idle(e(0, 0, R_M, 0, 1, 0, 0, 0), "r_mem");
    idle(e(0, 0, 0, 0, 0, R_WB, 1, 0), "r_wb");
    idle(e(0, 0, 0, 0, 0, 0, 0, 1), "r_retired");

    step(0, 1, 0, 0, LW_EX, LW_M, LW_WB, e(LW_EX, 1, 0, 0, 0, 0, 0, 1), "lw_ex");
    step(0, 1, 1, 0, R_EX, R_M, R_WB, e(0, 0, LW_M, 0, 1, 0, 0, 1), "stall_bubble");
    step(0, 1, 0, 0, R_EX, R_M, R_WB, e(R_EX, 1, 0, 0, 0, LW_WB, 1, 1), "dep_ex");
    idle(e(0, 0, R_M, 0, 1, 0, 0, 2), "dep_mem");
    idle(e(0, 0, 0, 0, 0, R_WB, 1, 2), "dep_wb");
    idle(e(0, 0, 0, 0, 0, 0, 0, 3), "lw_retired2");

    step(0, 1, 0, 0, BQ_EX, BQ_M, BQ_WB, e(BQ_EX, 1, 0, 0, 0, 0, 0, 3), "tk_beq_ex");
    step(0, 1, 0, 1, SW_EX, SW_M, SW_WB, e(SW_EX, 1, BQ_M, 1, 1, 0, 0, 3), "tk_pcsrc");
    step(0, 1, 0, 0, SW_EX, SW_M, SW_WB, e(0, 0, 0, 0, 0, BQ_WB, 1, 3), "tk_squash");
    idle(e(0, 0, 0, 0, 0, 0, 0, 4), "tk_retired");
    idle(e(0, 0, 0, 0, 0, 0, 0, 4), "tk_quiet");

    step(0, 1, 0, 0, BQ_EX, BQ_M, BQ_WB, e(BQ_EX, 1, 0, 0, 0, 0, 0, 4), "nt_beq_ex");
    step(0, 1, 0, 0, SW_EX, SW_M, SW_WB, e(SW_EX, 1, BQ_M, 0, 1, 0, 0, 4), "nt_no_pcsrc");
    step(0, 1, 0, 0, SW_EX, SW_M, SW_WB, e(SW_EX, 1, SW_M, 0, 1, BQ_WB, 1, 4), "nt_sw1_mem");
    idle(e(0, 0, SW_M, 0, 1, SW_WB, 1, 5), "nt_sw2_mem");
    idle(e(0, 0, 0, 0, 0, SW_WB, 1, 6), "nt_sw2_wb");
    idle(e(0, 0, 0, 0, 0, 0, 0, 7), "nt_retired");

    step(0, 1, 0, 0, BQ_EX, BQ_M, BQ_WB, e(BQ_EX, 1, 0, 0, 0, 0, 0, 7), "fs_beq_ex");
    step(0, 1, 0, 1, R_EX, R_M, R_WB, e(R_EX, 1, BQ_M, 1, 1, 0, 0, 7), "fs_pcsrc");
    step(0, 1, 1, 0, R_EX, R_M, R_WB, e(0, 0, 0, 0, 0, BQ_WB, 1, 7), "fs_flush_stall");
    idle(e(0, 0, 0, 0, 0, 0, 0, 8), "fs_retired");

    step(0, 1, 0, 0, R_EX, R_M, R_WB, e(R_EX, 1, 0, 0, 0, 0, 0, 8), "mr_ex");
    step(1, 1, 0, 0, R_EX, R_M, R_WB, e(0, 0, 0, 0, 0, 0, 0, 0), "mr_clear");

    for (int k = 1; k <= 17; k++) begin
      mv = (k >= 2);
      wv = (k >= 3);
      w  = wv ? R_WB : 2'b00;
      r  = 4'((k >= 3) ? k - 3 : 0);
      step(0, 1, 0, 0, R_EX, R_M, R_WB, e(R_EX, 1, R_M, 0, mv, w, wv, r), "wrap_stream");
    end
    idle(e(0, 0, R_M, 0, 1, R_WB, 1, 15), "wrap_drain1");
    idle(e(0, 0, 0, 0, 0, R_WB, 1, 0), "wrap_to_zero");
    idle(e(0, 0, 0, 0, 0, 0, 0, 1), "wrap_one");

    repeat (5) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
